array8_seq_ctrl: RTL
====================

Name: array8_seq_ctrl

Overview:
- Iterative 8x8 unsigned multiplier controller.
- Time-shares a single 4x4 array multiplier (existing array4) across four partial-product steps and accumulates into a 16-bit result.
- Trades throughput for area: one 4x4 array instead of four.
- Sits between an operand producer (valid/ready) and a result consumer (valid/ready); the drop-in area-reduced alternative to the fully parallel 8x8 array.

Parameters:
- DW, 8, operand width; must be 8 in this revision (4-bit halves map onto array4).
- HW, DW/2, half width; local, not overridable.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous abort; returns the FSM to IDLE
- in_valid  in  1  operands valid
- in_ready  out  1  controller can accept operands
- a  in  8  multiplicand
- b  in  8  multiplier
- out_valid  out  1  product valid
- out_ready  in  1  consumer accepts product
- p  out  16  product a*b
- busy  out  1  high in any state other than IDLE
- op_count  out  8  completed-and-delivered products, wraps 255->0

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, step=0.
  - acc=0, p=0, out_valid=0, in_ready=1 (combinational from IDLE), busy=0, op_count=0.
  - Operand registers a_q/b_q=0.
- States:
  - IDLE: in_ready=1. When in_valid&in_ready, capture a->a_q, b->b_q, acc<=0, step<=0, go to MUL.
  - MUL: one partial product per cycle. The array4 inputs are muxed by step:
    - step0: a_q[3:0]*b_q[3:0], added at shift 0
    - step1: a_q[7:4]*b_q[3:0], added at shift 4
    - step2: a_q[3:0]*b_q[7:4], added at shift 4
    - step3: a_q[7:4]*b_q[7:4], added at shift 8
    - acc <= acc + ({8'b0,pp} << shift), 16-bit add. Carry out of bit 15 cannot occur; max 255*255=65025.
    - step increments each cycle; after step3, p<=final acc and go to DONE.
  - DONE: out_valid=1 and p held stable until out_ready. On out_valid&out_ready, op_count++ and go to IDLE.
- Latency:
  - Accept edge at cycle T; MUL occupies T+1..T+4; out_valid is high from cycle T+5.
  - Minimum issue interval is 6 cycles: accept, 4 MUL, 1 DONE handshake, then back in IDLE.
- in_ready is low in MUL and DONE; there is no skid buffer and no overlap of operations.
- Back-pressure: out_valid is held in DONE indefinitely; p and op_count do not change while stalled.
- clear:
  - Highest priority over all transitions.
  - Next state is IDLE, step=0, out_valid=0; the in-flight result is discarded and op_count is unchanged.
  - clear in IDLE with in_valid=1: no capture that cycle (in_ready forced 0 while clear=1).
  - p keeps its last value after clear.
- Simultaneous out_valid&out_ready and clear: clear wins; no count increment.
- Reset mid-operation: asynchronous return to reset values. No partial result is emitted after deassertion.
- in_valid may drop without acceptance while in_ready=0; no effect.
- Operands are sampled only at the accept edge; changes to a/b afterwards do not affect p.
- op_count wraps modulo 256 with no flag.

Decomposition:
- Shared package array_mul_pkg:
  - constants MUL_DW=8, MUL_HW=4, MUL_PW=16
  - state enum {IDLE, MUL, DONE}, 2 bits
  - step-to-shift table: 0,4,4,8
- Sub-module: the existing array4 4x4 multiplier, instantiated once inside array8_seq_ctrl.
- No other sub-modules; FSM, mux and accumulator are inline.

Test Plan:
- Single op a=8'hFF, b=8'hFF, out_ready=1 -> out_valid at T+5, p=16'hFE01, op_count=1, busy low after handshake.
- Sweep all 65536 a/b pairs back-to-back, out_ready=1 -> each p equals a*b, issue interval exactly 6 cycles, op_count wraps to 0 after 256 ops.
- a=8'h12, b=8'h34, out_ready=0 for 10 cycles then 1 -> p=16'h03A8 stable and out_valid high throughout the stall, in_ready=0 until the handshake.
- clear asserted at T+2 (during MUL) -> out_valid never rises for that op, in_ready=1 next cycle, op_count unchanged; the next op a=3, b=5 gives p=15.
- rst_n pulsed low asynchronously mid-MUL (between clock edges) -> all outputs immediately take reset values, and no out_valid after release.
- in_valid=1 while clear=1 in IDLE -> no capture; operands a=7, b=9 presented the next cycle give p=63.

Source files
------------

// File: rtl/array_mul_pkg.sv
// Shared definitions for the sequential array multiplier family.
package array_mul_pkg;

  localparam int unsigned MUL_DW = 8;
  localparam int unsigned MUL_HW = 4;
  localparam int unsigned MUL_PW = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Weight of each partial product: lo*lo, hi*lo, lo*hi, hi*hi.
  function automatic logic [3:0] step_shift(input logic [1:0] step);
    logic [3:0] sh;
    case (step)
      2'd0:    sh = 4'd0;
      2'd1:    sh = 4'd4;
      2'd2:    sh = 4'd4;
      default: sh = 4'd8;
    endcase
    return sh;
  endfunction

endpackage

// File: rtl/array4.sv
// 4x4 unsigned array multiplier: AND-gated shifted rows summed combinationally.
module array4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);

  // Sum one shifted copy of a per set bit of b.
  always_comb begin
    p = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (b[i]) p = p + ({4'b0, a} << i);
    end
  end

endmodule

// File: rtl/array8_seq_ctrl.sv
// Iterative 8x8 multiplier: one shared array4 stepped over four partial products.
module array8_seq_ctrl
  import array_mul_pkg::*;
#(
  parameter int unsigned DW = MUL_DW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*DW-1:0] p,
  output logic            busy,
  output logic [7:0]      op_count
);

  localparam int unsigned HW = DW / 2;

  state_t              state_q, state_d;
  logic [1:0]          step_q;
  logic [DW-1:0]       a_q, b_q;
  logic [2*DW-1:0]     acc_q, p_q, acc_sum, pp_ext;
  logic [7:0]          op_count_q;
  logic [HW-1:0]       mul_a, mul_b;
  logic [2*HW-1:0]     pp;

  assign in_ready  = (state_q == IDLE) && !clear;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign p         = p_q;
  assign op_count  = op_count_q;

  // Step bit 0 selects the half of a, step bit 1 the half of b.
  always_comb begin
    mul_a   = step_q[0] ? a_q[DW-1:HW] : a_q[HW-1:0];
    mul_b   = step_q[1] ? b_q[DW-1:HW] : b_q[HW-1:0];
    pp_ext  = {{(2*DW-2*HW){1'b0}}, pp};
    acc_sum = acc_q + (pp_ext << step_shift(step_q));
  end

  array4 u_array4 (
    .a (mul_a),
    .b (mul_b),
    .p (pp)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; clear overrides every transition.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (in_valid) state_d = MUL;
        MUL:     if (step_q == 2'd3) state_d = DONE;
        DONE:    if (out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Operand capture, accumulation, result latch and delivered-op counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      p_q        <= '0;
      op_count_q <= '0;
    end else if (clear) begin
      step_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q    <= a;
            b_q    <= b;
            acc_q  <= '0;
            step_q <= '0;
          end
        end
        MUL: begin
          acc_q  <= acc_sum;
          step_q <= step_q + 2'd1;
          if (step_q == 2'd3) p_q <= acc_sum;
        end
        DONE: begin
          if (out_ready) op_count_q <= op_count_q + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
